// File: rtl/dht11_read_scheduler.sv
// DHT11 read scheduler: request capture, inter-read holdoff, watchdog, checksum
// verification and retry, and a latched last-good reading with a status code.
module dht11_read_scheduler #(
    parameter int MIN_GAP_CYCLES = 200_000_000,
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int MAX_RETRY      = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        req_ack_o,
    output logic        busy_o,
    output logic        sns_start_o,
    input  logic        sns_done_i,
    input  logic        sns_err_i,
    input  logic [39:0] sns_data_i,
    output logic [7:0]  hum_int_o,
    output logic [7:0]  hum_float_o,
    output logic [7:0]  temp_int_o,
    output logic [7:0]  temp_float_o,
    output logic        valid_o,
    output logic [1:0]  status_o,
    output logic        result_stb_o
);

    localparam int HW = (MIN_GAP_CYCLES > 1) ? $clog2(MIN_GAP_CYCLES) : 1;
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_GAP_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_CHK = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;
    localparam logic [1:0] ST_ERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GAP    = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_CHECK  = 3'd4,
        S_FAIL   = 3'd5,
        S_REPORT = 3'd6
    } state_t;

    // Sum of the four payload bytes, truncated to 8 bits, against the checksum byte.
    function automatic logic checksum_ok(input logic [39:0] d);
        logic [7:0] sum;
        sum = d[39:32] + d[31:24] + d[23:16] + d[15:8];
        return (sum == d[7:0]);
    endfunction

    state_t          state_q,   state_d;
    logic            pending_q, pending_d;
    logic [RW-1:0]   retry_q,   retry_d;
    logic [HW-1:0]   holdoff_q, holdoff_d;
    logic [WW-1:0]   wd_q,      wd_d;
    logic [39:0]     data_q,    data_d;
    logic [1:0]      code_q,    code_d;
    logic            ack_q,     ack_d;
    logic            busy_q,    busy_d;
    logic            start_q,   start_d;
    logic            stb_q,     stb_d;
    logic [1:0]      status_q,  status_d;
    logic [7:0]      hi_q, hi_d, hf_q, hf_d, ti_q, ti_d, tf_q, tf_d;
    logic            valid_q,   valid_d;

    // Next-state, counters and registered-output decode.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        retry_d   = retry_q;
        wd_d      = wd_q;
        data_d    = data_q;
        code_d    = code_q;
        ack_d     = 1'b0;
        stb_d     = 1'b0;
        status_d  = status_q;
        hi_d      = hi_q;
        hf_d      = hf_q;
        ti_d      = ti_q;
        tf_d      = tf_q;
        valid_d   = valid_q;

        if (state_q == S_START) begin
            holdoff_d = HOLD_LOAD;
        end else if (holdoff_q != '0) begin
            holdoff_d = holdoff_q - HW'(1);
        end else begin
            holdoff_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    state_d = S_GAP;
                    retry_d = '0;
                end else if (req_i) begin
                    pending_d = 1'b1;
                    ack_d     = 1'b1;
                end else begin
                    pending_d = 1'b0;
                end
            end
            S_GAP: begin
                if (holdoff_q == '0) begin
                    state_d = S_START;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_START: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + WW'(1);
                // A protocol error outranks a simultaneous done.
                if (sns_err_i) begin
                    code_d  = ST_ERR;
                    state_d = S_FAIL;
                end else if (sns_done_i) begin
                    data_d  = sns_data_i;
                    state_d = S_CHECK;
                end else if (wd_q == WD_LAST) begin
                    code_d  = ST_TMO;
                    state_d = S_FAIL;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_CHECK: begin
                if (checksum_ok(data_q)) begin
                    code_d  = ST_OK;
                    state_d = S_REPORT;
                end else begin
                    code_d  = ST_CHK;
                    state_d = S_FAIL;
                end
            end
            S_FAIL: begin
                if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + RW'(1);
                    state_d = S_GAP;
                end else begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                stb_d    = 1'b1;
                status_d = code_q;
                if (code_q == ST_OK) begin
                    hi_d    = data_q[39:32];
                    hf_d    = data_q[31:24];
                    ti_d    = data_q[23:16];
                    tf_d    = data_q[15:8];
                    valid_d = 1'b1;
                end else begin
                    valid_d = valid_q;
                end
                pending_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        start_d = (state_d == S_START);
        busy_d  = pending_d | (state_d != S_IDLE);
    end

    // State and output registers; reset re-arms the power-up holdoff.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            retry_q   <= '0;
            holdoff_q <= HOLD_LOAD;
            wd_q      <= '0;
            data_q    <= 40'h00_0000_0000;
            code_q    <= 2'b00;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            stb_q     <= 1'b0;
            status_q  <= 2'b00;
            hi_q      <= 8'h00;
            hf_q      <= 8'h00;
            ti_q      <= 8'h00;
            tf_q      <= 8'h00;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            retry_q   <= retry_d;
            holdoff_q <= holdoff_d;
            wd_q      <= wd_d;
            data_q    <= data_d;
            code_q    <= code_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            stb_q     <= stb_d;
            status_q  <= status_d;
            hi_q      <= hi_d;
            hf_q      <= hf_d;
            ti_q      <= ti_d;
            tf_q      <= tf_d;
            valid_q   <= valid_d;
        end
    end

    assign req_ack_o    = ack_q;
    assign busy_o       = busy_q;
    assign sns_start_o  = start_q;
    assign result_stb_o = stb_q;
    assign status_o     = status_q;
    assign hum_int_o    = hi_q;
    assign hum_float_o  = hf_q;
    assign temp_int_o   = ti_q;
    assign temp_float_o = tf_q;
    assign valid_o      = valid_q;

endmodule
